// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  localparam int PC_W_DEFAULT = 3;
  localparam int PC_INC = 1;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    BR_CALC   = 2'd1,
    BR_COMMIT = 2'd2,
    HALTED    = 2'd3
  } state_t;

endpackage

// File: rtl/pc_branch_seq.sv
// PC sequencer feeding an external add_alu: increments on fetch handshake, takes relative branches.
// Optional sticky wrap flag port enabled by defining PC_SEQ_WRAP_FLAG_EN.
module pc_branch_seq
  import pc_seq_pkg::*;
#(
  parameter int PC_W     = PC_W_DEFAULT,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  input  logic            pc_ready,
  input  logic            halt,
  input  logic            br_req,
  input  logic [PC_W-1:0] br_off,
  output logic            br_ack,
  output logic            busy,
  output logic [PC_W-1:0] alu_a,
  output logic [PC_W-1:0] alu_b,
  input  logic [PC_W-1:0] alu_g,
  output logic            alu_rst
`ifdef PC_SEQ_WRAP_FLAG_EN
  ,
  output logic            pc_wrap
`endif
);

  state_t          state;
  state_t          next_state;
  logic [PC_W-1:0] off_q;
  logic [PC_W-1:0] tgt_q;
  logic [PC_W-1:0] pc_next;
  logic            pc_load;
  logic            off_load;
  logic            tgt_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= PC_W'(RESET_PC);
      off_q <= '0;
      tgt_q <= '0;
    end else begin
      state <= next_state;
      if (pc_load)  pc    <= pc_next;
      if (off_load) off_q <= br_off;
      if (tgt_load) tgt_q <= alu_g;
    end
  end

  // Branch request outranks halt, which outranks the fetch increment.
  always_comb begin
    next_state = state;
    pc_next    = pc;
    pc_load    = 1'b0;
    off_load   = 1'b0;
    tgt_load   = 1'b0;
    case (state)
      RUN: begin
        if (br_req) begin
          off_load   = 1'b1;
          next_state = BR_CALC;
        end else if (halt) begin
          next_state = HALTED;
        end else if (pc_ready) begin
          pc_next = alu_g;
          pc_load = 1'b1;
        end
      end
      BR_CALC: begin
        tgt_load   = 1'b1;
        next_state = BR_COMMIT;
      end
      BR_COMMIT: begin
        pc_next    = tgt_q;
        pc_load    = 1'b1;
        next_state = RUN;
      end
      HALTED: begin
        if (!halt) next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

  assign pc_valid = (state == RUN);
  assign busy     = (state == BR_CALC) || (state == BR_COMMIT);
  assign br_ack   = (state == BR_COMMIT);
  assign alu_a    = pc;
  assign alu_b    = (state == BR_CALC) ? off_q : PC_W'(PC_INC);
  assign alu_rst  = ~rst_n;

`ifdef PC_SEQ_WRAP_FLAG_EN
  // Any PC update that lands below the old value means the sum wrapped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_wrap <= 1'b0;
    end else if (pc_load && (pc_next < pc)) begin
      pc_wrap <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_branch_seq.sv
// Testbench for pc_branch_seq: directed vector table, hand sequences and randomized run vs. a model.
// Covers the optional pc_wrap port when PC_SEQ_WRAP_FLAG_EN is defined.
module tb_pc_branch_seq;

  localparam int W    = 3;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] pc;
  logic         pc_valid;
  logic         pc_ready = 1'b0;
  logic         halt = 1'b0;
  logic         br_req = 1'b0;
  logic [W-1:0] br_off = '0;
  logic         br_ack;
  logic         busy;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_g;
  logic         alu_rst;
`ifdef PC_SEQ_WRAP_FLAG_EN
  logic         pc_wrap;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: current pc, halted flag, and remaining branch bubble cycles.
  int m_pc, m_wrap, m_halted, m_left, m_off, m_tgt;

  always #5 clk = ~clk;

  // The adder sitting beside the sequencer at the parent level.
  assign alu_g = alu_a + alu_b;

  pc_branch_seq #(.PC_W(W), .RESET_PC(0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc(pc),
    .pc_valid(pc_valid),
    .pc_ready(pc_ready),
    .halt(halt),
    .br_req(br_req),
    .br_off(br_off),
    .br_ack(br_ack),
    .busy(busy),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_g(alu_g),
    .alu_rst(alu_rst)
`ifdef PC_SEQ_WRAP_FLAG_EN
    ,
    .pc_wrap(pc_wrap)
`endif
  );

  typedef struct {
    logic         br;
    logic [W-1:0] off;
    logic         hlt;
    logic         rdy;
    logic [W-1:0] e_pc;
    logic         e_valid;
    logic         e_ack;
    logic         e_busy;
    logic [W-1:0] e_alu_b;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(logic br, int off, logic hlt, logic rdy,
                              int e_pc, logic e_valid, logic e_ack, logic e_busy, int e_alu_b);
    vec_t v;
    v.br = br; v.off = W'(off); v.hlt = hlt; v.rdy = rdy;
    v.e_pc = W'(e_pc); v.e_valid = e_valid; v.e_ack = e_ack; v.e_busy = e_busy;
    v.e_alu_b = W'(e_alu_b);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_pc = 0; m_wrap = 0; m_halted = 0; m_left = 0; m_off = 0; m_tgt = 0;
  endtask

  task automatic modelStep(input logic br, input int off, input logic hlt, input logic rdy);
    int old_pc;
    old_pc = m_pc;
    if (m_left == 2) begin
      m_left = 1;
    end else if (m_left == 1) begin
      m_pc = m_tgt;
      m_left = 0;
    end else if (m_halted != 0) begin
      if (!hlt) m_halted = 0;
    end else if (br) begin
      m_off = off;
      m_tgt = (m_pc + off) & MASK;
      m_left = 2;
    end else if (hlt) begin
      m_halted = 1;
    end else if (rdy) begin
      m_pc = (m_pc + 1) & MASK;
    end
    if (m_pc < old_pc) m_wrap = 1;
  endtask

  task automatic applyStimulus(input logic br, input int off, input logic hlt, input logic rdy);
    br_req = br;
    br_off = W'(off);
    halt = hlt;
    pc_ready = rdy;
  endtask

  task automatic checkOutput();
    @(negedge clk);
    check("pc", 32'(pc), 32'(m_pc));
    check("pc_valid", 32'(pc_valid), 32'(m_left == 0 && m_halted == 0));
    check("br_ack", 32'(br_ack), 32'(m_left == 1));
    check("busy", 32'(busy), 32'(m_left != 0));
    check("alu_a", 32'(alu_a), 32'(m_pc));
    check("alu_b", 32'(alu_b), (m_left == 2) ? 32'(m_off) : 32'd1);
    check("alu_rst", 32'(alu_rst), 32'd0);
`ifdef PC_SEQ_WRAP_FLAG_EN
    check("pc_wrap", 32'(pc_wrap), 32'(m_wrap));
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    modelStep(br_req, int'(br_off), halt, pc_ready);
    #1;
  endtask

  task automatic cyc(input logic br, input int off, input logic hlt, input logic rdy);
    applyStimulus(br, off, hlt, rdy);
    checkOutput();
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic hold_br;
    logic [W-1:0] hold_off;

    for (int i = 0; i < 8; i++) tbl[i] = mk(1'b0, 0, 1'b0, 1'b1, i, 1'b1, 1'b0, 1'b0, 1);
    tbl[8]  = mk(1'b0, 0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1);
    tbl[9]  = mk(1'b0, 0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1);
    tbl[10] = mk(1'b0, 0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1);
    for (int i = 11; i < 15; i++) tbl[i] = mk(1'b0, 0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1);
    tbl[15] = mk(1'b0, 0, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1);
    tbl[16] = mk(1'b0, 0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1);
    tbl[17] = mk(1'b0, 0, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1);
    tbl[18] = mk(1'b0, 0, 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1);
    tbl[19] = mk(1'b0, 0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1);
    tbl[20] = mk(1'b0, 0, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1);
    tbl[21] = mk(1'b0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1);
    tbl[22] = mk(1'b1, 3, 1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1);
    tbl[23] = mk(1'b1, 3, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b1, 3);
    tbl[24] = mk(1'b1, 3, 1'b0, 1'b1, 5, 1'b0, 1'b1, 1'b1, 1);
    tbl[25] = mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1);

    // Reset state, sampled while reset is still asserted.
    modelReset();
    #3;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd1);
    check("rst_pc_valid", 32'(pc_valid), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_br_ack", 32'(br_ack), 32'd0);
    check("rst_alu_rst", 32'(alu_rst), 32'd1);
    resetDut();

    // Directed table: sequential wrap, stall, halt, branch landing on a wrapped target.
    for (int i = 0; i < 26; i++) begin
      cyc(tbl[i].br, int'(tbl[i].off), tbl[i].hlt, tbl[i].rdy);
      check($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].e_pc));
      check($sformatf("tbl%0d_valid", i), 32'(pc_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_ack", i), 32'(br_ack), 32'(tbl[i].e_ack));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("tbl%0d_alu_b", i), 32'(alu_b), 32'(tbl[i].e_alu_b));
      advance();
    end
`ifdef PC_SEQ_WRAP_FLAG_EN
    check("tbl_wrap_sticky", 32'(pc_wrap), 32'd1);
`endif

    // Forward branch from pc=2 with offset 3.
    resetDut();
    cyc(1'b0, 0, 1'b0, 1'b1); advance();
    cyc(1'b0, 0, 1'b0, 1'b1); advance();
    cyc(1'b1, 3, 1'b0, 1'b1);
    check("fb_req_pc", 32'(pc), 32'd2);
    advance();
    cyc(1'b1, 3, 1'b0, 1'b1);
    check("fb_calc_alu_a", 32'(alu_a), 32'd2);
    check("fb_calc_alu_b", 32'(alu_b), 32'd3);
    check("fb_calc_ack", 32'(br_ack), 32'd0);
    advance();
    cyc(1'b1, 3, 1'b0, 1'b1);
    check("fb_commit_ack", 32'(br_ack), 32'd1);
    advance();
    cyc(1'b0, 0, 1'b0, 1'b0);
    check("fb_target_pc", 32'(pc), 32'd5);
    check("fb_target_valid", 32'(pc_valid), 32'd1);
    check("fb_ack_dropped", 32'(br_ack), 32'd0);
    advance();

    // Branch wrap from pc=6 with offset 3.
    resetDut();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 0, 1'b0, 1'b1); advance();
    end
`ifdef PC_SEQ_WRAP_FLAG_EN
    check("bw_wrap_before", 32'(pc_wrap), 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 3, 1'b0, 1'b0); advance();
    end
    cyc(1'b0, 0, 1'b0, 1'b0);
    check("bw_target_pc", 32'(pc), 32'd1);
`ifdef PC_SEQ_WRAP_FLAG_EN
    check("bw_wrap_after", 32'(pc_wrap), 32'd1);
`endif
    advance();

    // Halt raised during BR_CALC: branch completes, then HALTED.
    resetDut();
    cyc(1'b1, 2, 1'b0, 1'b0); advance();
    cyc(1'b1, 2, 1'b1, 1'b0); advance();
    cyc(1'b1, 2, 1'b1, 1'b0);
    check("hb_commit_ack", 32'(br_ack), 32'd1);
    advance();
    cyc(1'b0, 0, 1'b1, 1'b0);
    check("hb_run_pc", 32'(pc), 32'd2);
    check("hb_run_valid", 32'(pc_valid), 32'd1);
    advance();
    cyc(1'b0, 0, 1'b1, 1'b1);
    check("hb_halted_valid", 32'(pc_valid), 32'd0);
    check("hb_halted_pc", 32'(pc), 32'd2);
    advance();
    cyc(1'b0, 0, 1'b0, 1'b1); advance();
    cyc(1'b0, 0, 1'b0, 1'b0);
    check("hb_resume_valid", 32'(pc_valid), 32'd1);
    check("hb_resume_pc", 32'(pc), 32'd2);
    advance();

    // Reset asserted during BR_CALC drops the branch immediately.
    resetDut();
    cyc(1'b0, 0, 1'b0, 1'b1); advance();
    cyc(1'b1, 4, 1'b0, 1'b0); advance();
    rst_n = 1'b0;
    #1;
    check("rb_pc", 32'(pc), 32'd0);
    check("rb_busy", 32'(busy), 32'd0);
    check("rb_ack", 32'(br_ack), 32'd0);
    check("rb_alu_rst", 32'(alu_rst), 32'd1);
    check("rb_valid", 32'(pc_valid), 32'd1);
    modelReset();
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("rb_ack_held", 32'(br_ack), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b0, 0, 1'b0, 1'b0);
    advance();

    // Randomized run against the reference model.
    resetDut();
    hold_br = 1'b0;
    hold_off = '0;
    for (int i = 0; i < 600; i++) begin
      if (m_left == 0) begin
        hold_br = ($urandom_range(0, 3) == 0);
        hold_off = W'($urandom_range(0, MASK));
      end
      cyc(hold_br, int'(hold_off), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_branch_seq.md
# pc_branch_seq

Program-counter sequencer that sits directly upstream of `add_alu` in the branch datapath. It drives the adder's operands (current PC plus either the constant 1 or a captured branch offset) and registers the adder's sum back as the next PC. A valid/ready handshake presents the PC to fetch, and a req/ack handshake accepts branch requests.

## Interface
- `PC_W`, default 3: PC and offset width; all arithmetic is modulo 2^PC_W.
- `RESET_PC`, default 0: PC value loaded on reset.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc`  out  PC_W  current program counter.
- `pc_valid`  out  1  `pc` is presentable to fetch.
- `pc_ready`  in  1  fetch accepts `pc` this cycle.
- `halt`  in  1  level; freeze sequencing while high.
- `br_req`  in  1  level branch request; held until `br_ack`.
- `br_off`  in  PC_W  unsigned forward offset; valid while `br_req` is high.
- `br_ack`  out  1  one-cycle branch-complete pulse.
- `busy`  out  1  branch in progress.
- `alu_a`  out  PC_W  adder operand a (always `pc`).
- `alu_b`  out  PC_W  adder operand b.
- `alu_g`  in  PC_W  adder sum, combinational from `alu_a`/`alu_b`.
- `alu_rst`  out  1  `~rst_n`, drives the adder's active-high `rst`.
- `pc_wrap`  out  1  sticky wrap flag. Present only with `PC_SEQ_WRAP_FLAG_EN`.

## Operation
- The FSM has four states: RUN, BR_CALC, BR_COMMIT, HALTED. It resets to RUN.
- **RUN:**
  - `pc_valid` is 1 and `alu_b` is 1.
  - On `pc_valid & pc_ready`, `pc <= alu_g` (increment). Otherwise `pc` holds.
- **Priority in RUN:** `br_req` > `halt` > increment.
- **Branch entry:** `br_req` sampled high in RUN causes `off_q <= br_off` and a move to BR_CALC. `pc` does not increment, even if `pc_ready` was high.
  - The target is relative to the PC presented in that cycle.
- **BR_CALC:**
  - `pc_valid` is 0, `alu_b` is `off_q`, and `busy` is 1.
  - Next edge: `tgt_q <= alu_g`, then BR_COMMIT.
- **BR_COMMIT:**
  - `br_ack` is 1 (decoded from state), `busy` is 1, and `pc_valid` is 0.
  - Next edge: `pc <= tgt_q`, then RUN.
- **Requester rule:** the requester drops `br_req` at the edge where it samples `br_ack` high. A `br_req` still high in the following RUN cycle is treated as a new branch.
- **Halt:**
  - `halt` sampled high in RUN (with no `br_req`) moves to HALTED.
  - In HALTED, `pc_valid` is 0 and `pc` holds. When `halt` is low, return to RUN.
  - `halt` is ignored in BR_CALC and BR_COMMIT. The branch completes first; if `halt` is still high, HALTED is entered from RUN.
- **Wrap:** 7+1 wraps to 0 at PC_W=3, and branch sums wrap modulo 2^PC_W. No error is raised.
- **Reset values:**
  - `pc` = `alu_a` = RESET_PC, `alu_b` = 1.
  - `pc_valid` = 1, `br_ack` = 0, `busy` = 0, `pc_wrap` = 0.
  - `off_q` = `tgt_q` = 0, `alu_rst` = 1.

## Timing
- Increment: one cycle per accepted handshake; the new `pc` is visible the cycle after acceptance.
- Branch: `br_req` sampled at edge N → BR_CALC during cycle N+1 → BR_COMMIT (`br_ack` high) during cycle N+2 → new `pc` with `pc_valid=1` in cycle N+3. This gives two bubble cycles.
- `alu_g` has a combinational path only into `pc`/`tgt_q` registers; no output depends combinationally on `alu_g`.
- Reset mid-operation: asynchronous return to RUN with reset values. Any branch in flight is dropped and `br_ack` is never issued.

## Configuration
- `PC_SEQ_WRAP_FLAG_EN` defined:
  - The `pc_wrap` port exists.
  - It is set on any `pc` update where new `pc` < old `pc`.
  - It is cleared only by reset.
- Undefined: the port and flag logic are absent; behaviour is otherwise identical.

## Structure
- Shared package `pc_seq_pkg`:
  - state enum (RUN, BR_CALC, BR_COMMIT, HALTED);
  - default `PC_W`;
  - increment constant `PC_INC = 1`.
- No sub-module. `add_alu` is instantiated beside this block at the parent level, not inside it.

## Test plan
- **Sequential wrap:** reset with RESET_PC=0, `pc_ready=1` for 9 cycles → `pc` runs 0,1,…,7,0; `pc_wrap`=1 after the 7→0 update (macro on).
- **Stall:** at `pc=3`, `pc_ready=0` for 4 cycles → `pc` stays 3 and `pc_valid` stays 1; it advances to 4 one cycle after `pc_ready=1`.
- **Forward branch:** at `pc=2`, `br_req=1`, `br_off=3`:
  - BR_CALC shows `alu_a=2`, `alu_b=3`;
  - `br_ack` is high for exactly one cycle;
  - `pc=5` with `pc_valid=1` three cycles after the request edge.
- **Branch wrap:** at `pc=6`, `br_off=3` → `pc=1` and `pc_wrap=1`.
- **Halt:**
  - `halt=1` at `pc=4` → `pc_valid=0` and `pc` holds 4; release → resumes at 4.
  - `halt` raised during BR_CALC → branch completes to target, then HALTED.
- **Reset mid-branch:** `rst_n=0` during BR_CALC → immediately `pc=RESET_PC`, `busy=0`, `br_ack=0`, `alu_rst=1`; after release, RUN with `pc_valid=1`.
